// File: rtl/usb2_ep_ring_pkg.sv
// usb2_ep_pkg: shared endpoint-type and PID-selector encodings for the endpoint ring
package usb2_ep_pkg;

    typedef enum logic [1:0] {
        EP_MODE_CONTROL   = 2'd0,
        EP_MODE_ISOCH     = 2'd1,
        EP_MODE_BULK      = 2'd2,
        EP_MODE_INTERRUPT = 2'd3
    } ep_mode_t;

    localparam logic [1:0] DATA_TOGGLE_0 = 2'd0;
    localparam logic [1:0] DATA_TOGGLE_1 = 2'd1;
    localparam logic [1:0] DATA_TOGGLE_2 = 2'd2;
    localparam logic [1:0] DATA_TOGGLE_M = 2'd3;

    // Saturating 8-bit event counter add of up to two events per cycle
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, inc};
        return s[8] ? 8'hff : s[7:0];
    endfunction

endpackage

// File: rtl/usb2_ep_ring_ram.sv
// usb2_ep_ring_ram: simple dual-port single-clock RAM with registered read data
module usb2_ep_ring_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] q_q;

    // Write port; no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port returns pre-write contents on a same-address collision
    always_ff @(posedge clk) begin
        q_q <= rst ? '0 : mem[raddr];
    end

    assign q = q_q;

endmodule

// File: rtl/usb2_ep_ring.sv
// usb2_ep_ring: N-slot USB 2.0 endpoint buffer ring with fill level and ISO PID sequencing.
// Optional statistics counters (ovf_cnt/udf_cnt) are built when USB2_EP_RING_STATS_EN is defined.
module usb2_ep_ring
    import usb2_ep_pkg::*;
#(
    parameter int NUM_BUF  = 4,
    parameter int BUF_AW   = 10,
    parameter int ISO_MULT = 3,
    localparam int PW = $clog2(NUM_BUF),
    localparam int CW = PW + 1,
    localparam int LW = BUF_AW + 1
) (
    input  logic              phy_clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [BUF_AW-1:0] buf_in_addr,
    input  logic [7:0]        buf_in_data,
    input  logic              buf_in_wren,
    output logic              buf_in_ready,
    input  logic              buf_in_commit,
    input  logic [LW-1:0]     buf_in_commit_len,
    output logic              buf_in_commit_ack,
    input  logic [BUF_AW-1:0] buf_out_addr,
    output logic [7:0]        buf_out_q,
    output logic [LW-1:0]     buf_out_len,
    output logic              buf_out_hasdata,
    input  logic              buf_out_arm,
    output logic              buf_out_arm_ack,
    input  logic              buf_out_clear,
    input  logic              data_toggle_act,
    output logic [1:0]        data_toggle,
    input  logic              sof_arrived,
    output logic [CW-1:0]     fill_level
`ifdef USB2_EP_RING_STATS_EN
    ,
    output logic [7:0]        ovf_cnt,
    output logic [7:0]        udf_cnt
`endif
);

    localparam logic [LW-1:0] SLOT_BYTES = LW'(2**BUF_AW);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] len_q [NUM_BUF];
    logic [LW-1:0] len_d [NUM_BUF];
    logic [1:0]    tog_q, tog_d;
    logic          sof_q;
    logic          commit_ack_q, arm_ack_q;
    logic          full, empty, iso, sof_edge, commit_ok, arm_ok;
    logic [CW-1:0] iso_n;
    logic [1:0]    sof_tog, act_tog;
    logic [LW-1:0] clip_len;

    // Accept/reject decisions are made against the count at the start of the cycle
    always_comb begin
        full      = count_q == CW'(NUM_BUF);
        empty     = count_q == '0;
        iso       = ep_mode_t'(mode) == EP_MODE_ISOCH;
        sof_edge  = sof_arrived != sof_q;
        commit_ok = buf_in_commit && !full && !buf_out_clear;
        arm_ok    = buf_out_arm && !empty && !buf_out_clear;
        clip_len  = (buf_in_commit_len > SLOT_BYTES) ? SLOT_BYTES : buf_in_commit_len;
        wr_ptr_d  = buf_out_clear ? '0 : wr_ptr_q + PW'(commit_ok);
        rd_ptr_d  = buf_out_clear ? '0 : rd_ptr_q + PW'(arm_ok);
        count_d   = buf_out_clear ? '0 : count_q + CW'(commit_ok) - CW'(arm_ok);
        len_d     = len_q;
        if (commit_ok) len_d[wr_ptr_q] = clip_len;
    end

    // PID selection: ISO loads from the fill level on SOF and counts down per transaction
    always_comb begin
        iso_n   = (count_q > CW'(ISO_MULT)) ? CW'(ISO_MULT) : count_q;
        sof_tog = (iso_n == '0) ? DATA_TOGGLE_0 : 2'(iso_n - CW'(1));
        act_tog = iso ? ((tog_q == DATA_TOGGLE_0) ? DATA_TOGGLE_0 : tog_q - 2'd1)
                      : (tog_q[0] ? DATA_TOGGLE_0 : DATA_TOGGLE_1);
        tog_d   = buf_out_clear     ? DATA_TOGGLE_0 :
                  (iso && sof_edge) ? sof_tog :
                  data_toggle_act   ? act_tog : tog_q;
    end

    // Ring state, acknowledge pulses and SOF edge tracking
    always_ff @(posedge phy_clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tog_q        <= DATA_TOGGLE_0;
            commit_ack_q <= 1'b0;
            arm_ack_q    <= 1'b0;
            for (int i = 0; i < NUM_BUF; i++) len_q[i] <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tog_q        <= tog_d;
            commit_ack_q <= commit_ok;
            arm_ack_q    <= arm_ok;
            len_q        <= len_d;
        end
        sof_q <= sof_arrived;
    end

    usb2_ep_ring_ram #(
        .ADDR_W(PW + BUF_AW),
        .DATA_W(8)
    ) u_ram (
        .clk  (phy_clk),
        .rst  (reset),
        .we   (buf_in_wren && !full),
        .waddr({wr_ptr_q, buf_in_addr}),
        .wdata(buf_in_data),
        .raddr({rd_ptr_q, buf_out_addr}),
        .q    (buf_out_q)
    );

    assign buf_in_ready      = !full;
    assign buf_out_hasdata   = !empty;
    assign fill_level        = count_q;
    assign buf_out_len       = len_q[rd_ptr_q];
    assign buf_in_commit_ack = commit_ack_q;
    assign buf_out_arm_ack   = arm_ack_q;
    assign data_toggle       = tog_q;

`ifdef USB2_EP_RING_STATS_EN
    logic [7:0] ovf_q, ovf_d, udf_q, udf_d;

    // Rejected commits count as overflow; rejected arms and empty ISO microframes as underflow
    always_comb begin
        ovf_d = buf_out_clear ? 8'd0 : sat_add8(ovf_q, {1'b0, buf_in_commit && full});
        udf_d = buf_out_clear ? 8'd0 :
                sat_add8(udf_q, 2'(buf_out_arm && empty) + 2'(iso && sof_edge && empty));
    end

    // Statistics registers
    always_ff @(posedge phy_clk) begin
        ovf_q <= reset ? 8'd0 : ovf_d;
        udf_q <= reset ? 8'd0 : udf_d;
    end

    assign ovf_cnt = ovf_q;
    assign udf_cnt = udf_q;
`endif

endmodule

// File: tb/tb_usb2_ep_ring.sv
// tb_usb2_ep_ring: directed self-checking bench with a byte/length scoreboard for usb2_ep_ring
module tb_usb2_ep_ring;

    logic        phy_clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [9:0]  buf_in_addr = '0;
    logic [7:0]  buf_in_data = '0;
    logic        buf_in_wren = 1'b0;
    logic        buf_in_ready;
    logic        buf_in_commit = 1'b0;
    logic [10:0] buf_in_commit_len = '0;
    logic        buf_in_commit_ack;
    logic [9:0]  buf_out_addr = '0;
    logic [7:0]  buf_out_q;
    logic [10:0] buf_out_len;
    logic        buf_out_hasdata;
    logic        buf_out_arm = 1'b0;
    logic        buf_out_arm_ack;
    logic        buf_out_clear = 1'b0;
    logic        data_toggle_act = 1'b0;
    logic [1:0]  data_toggle;
    logic        sof_arrived = 1'b0;
    logic [2:0]  fill_level;
`ifdef USB2_EP_RING_STATS_EN
    logic [7:0]  ovf_cnt, udf_cnt;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0]  exp_bytes[$];
    logic [10:0] exp_lens[$];

    usb2_ep_ring #(.NUM_BUF(4), .BUF_AW(10), .ISO_MULT(3)) dut (
        .phy_clk(phy_clk), .reset(reset), .mode(mode),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
        .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
        .buf_out_addr(buf_out_addr), .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm(buf_out_arm),
        .buf_out_arm_ack(buf_out_arm_ack), .buf_out_clear(buf_out_clear),
        .data_toggle_act(data_toggle_act), .data_toggle(data_toggle),
        .sof_arrived(sof_arrived), .fill_level(fill_level)
`ifdef USB2_EP_RING_STATS_EN
        , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
    );

    always #5 phy_clk = ~phy_clk;

    task automatic step();
        @(posedge phy_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_slot(input int n, input int seed);
        for (int i = 0; i < n; i++) begin
            buf_in_addr = 10'(i);
            buf_in_data = 8'(seed * 7 + i * 13 + 1);
            buf_in_wren = 1'b1;
            step();
            exp_bytes.push_back(buf_in_data);
        end
        buf_in_wren = 1'b0;
        exp_lens.push_back(11'(n));
    endtask

    task automatic commit(input int len, input logic exp_ack, input string tag);
        buf_in_commit = 1'b1;
        buf_in_commit_len = 11'(len);
        step();
        buf_in_commit = 1'b0;
        check(tag, 32'(buf_in_commit_ack), 32'(exp_ack));
    endtask

    task automatic arm(input logic exp_ack, input string tag);
        buf_out_arm = 1'b1;
        step();
        buf_out_arm = 1'b0;
        check(tag, 32'(buf_out_arm_ack), 32'(exp_ack));
    endtask

    task automatic act(input logic [1:0] exp_tog, input string tag);
        data_toggle_act = 1'b1;
        step();
        data_toggle_act = 1'b0;
        check(tag, 32'(data_toggle), 32'(exp_tog));
    endtask

    task automatic read_slot();
        logic [10:0] n;
        n = exp_lens.pop_front();
        check("rd_len", 32'(buf_out_len), 32'(n));
        for (int i = 0; i < int'(n); i++) begin
            buf_out_addr = 10'(i);
            step();
            check("rd_data", 32'(buf_out_q), 32'(exp_bytes.pop_front()));
        end
    endtask

    initial begin
        step();
        step();
        check("rst_fill", 32'(fill_level), 0);
        check("rst_ready", 32'(buf_in_ready), 1);
        check("rst_hasdata", 32'(buf_out_hasdata), 0);
        check("rst_len", 32'(buf_out_len), 0);
        check("rst_q", 32'(buf_out_q), 0);
        check("rst_tog", 32'(data_toggle), 0);
        check("rst_acks", {30'd0, buf_in_commit_ack, buf_out_arm_ack}, 0);
        reset = 1'b0;
        step();

        for (int k = 0; k < 4; k++) begin
            write_slot(10 * (k + 1), k);
            commit(10 * (k + 1), 1'b1, "fill_ack");
        end
        check("full_ready", 32'(buf_in_ready), 0);
        check("full_fill", 32'(fill_level), 4);
        buf_in_addr = 10'd0;
        buf_in_data = 8'hEE;
        buf_in_wren = 1'b1;
        step();
        buf_in_wren = 1'b0;
        commit(5, 1'b0, "full_commit_rejected");
        check("full_fill_hold", 32'(fill_level), 4);
        for (int k = 0; k < 4; k++) begin
            read_slot();
            arm(1'b1, "drain_ack");
        end
        check("drain_hasdata", 32'(buf_out_hasdata), 0);
        check("drain_fill", 32'(fill_level), 0);
        arm(1'b0, "empty_arm_rejected");
        check("empty_fill_hold", 32'(fill_level), 0);

        commit(2047, 1'b1, "clip_ack");
        check("clip_len", 32'(buf_out_len), 1024);
        arm(1'b1, "clip_arm");

        for (int k = 0; k < 9; k++) begin
            write_slot(5, 100 + k);
            commit(5, 1'b1, "wrap_commit");
            read_slot();
            arm(1'b1, "wrap_arm");
        end

        for (int k = 0; k < 4; k++) commit(k + 1, 1'b1, "sim_fill");
        buf_in_commit = 1'b1;
        buf_out_arm = 1'b1;
        step();
        buf_in_commit = 1'b0;
        buf_out_arm = 1'b0;
        check("sim_full_arm_ack", 32'(buf_out_arm_ack), 1);
        check("sim_full_commit_ack", 32'(buf_in_commit_ack), 0);
        check("sim_full_fill", 32'(fill_level), 3);
        for (int k = 0; k < 3; k++) arm(1'b1, "sim_drain");
        buf_in_commit = 1'b1;
        buf_out_arm = 1'b1;
        step();
        buf_in_commit = 1'b0;
        buf_out_arm = 1'b0;
        check("sim_empty_commit_ack", 32'(buf_in_commit_ack), 1);
        check("sim_empty_arm_ack", 32'(buf_out_arm_ack), 0);
        check("sim_empty_fill", 32'(fill_level), 1);
        arm(1'b1, "sim_empty_drain");

        mode = 2'd1;
        for (int k = 0; k < 3; k++) commit(1, 1'b1, "iso_commit");
        sof_arrived = ~sof_arrived;
        step();
        check("iso_sof3", 32'(data_toggle), 2);
        act(2'd1, "iso_act1");
        act(2'd0, "iso_act2");
        act(2'd0, "iso_act_sat");
        arm(1'b1, "iso_arm");
        arm(1'b1, "iso_arm");
        sof_arrived = ~sof_arrived;
        step();
        check("iso_sof1", 32'(data_toggle), 0);
        for (int k = 0; k < 3; k++) commit(1, 1'b1, "iso_commit4");
        sof_arrived = ~sof_arrived;
        data_toggle_act = 1'b1;
        step();
        data_toggle_act = 1'b0;
        check("iso_sof_beats_act", 32'(data_toggle), 2);
        act(2'd1, "iso_act_after");

        mode = 2'd2;
        act(2'd0, "bulk_act0");
        act(2'd1, "bulk_act1");
        act(2'd0, "bulk_act2");
        act(2'd1, "bulk_act3");
        buf_out_clear = 1'b1;
        buf_in_commit = 1'b1;
        buf_in_commit_len = 11'd7;
        step();
        buf_out_clear = 1'b0;
        buf_in_commit = 1'b0;
        check("clr_commit_ack", 32'(buf_in_commit_ack), 0);
        check("clr_tog", 32'(data_toggle), 0);
        check("clr_fill", 32'(fill_level), 0);
        check("clr_hasdata", 32'(buf_out_hasdata), 0);
        check("clr_ready", 32'(buf_in_ready), 1);

        commit(3, 1'b1, "mid_commit");
        commit(4, 1'b1, "mid_commit");
        reset = 1'b1;
        buf_in_commit = 1'b1;
        step();
        reset = 1'b0;
        buf_in_commit = 1'b0;
        check("mid_rst_fill", 32'(fill_level), 0);
        check("mid_rst_ready", 32'(buf_in_ready), 1);
        check("mid_rst_acks", {30'd0, buf_in_commit_ack, buf_out_arm_ack}, 0);
        check("mid_rst_len", 32'(buf_out_len), 0);

`ifdef USB2_EP_RING_STATS_EN
        check("st_ovf0", 32'(ovf_cnt), 0);
        for (int k = 0; k < 4; k++) commit(1, 1'b1, "st_fill");
        buf_in_commit = 1'b1;
        for (int k = 0; k < 300; k++) step();
        buf_in_commit = 1'b0;
        check("st_ovf_sat", 32'(ovf_cnt), 255);
        for (int k = 0; k < 4; k++) arm(1'b1, "st_drain");
        arm(1'b0, "st_udf_arm");
        check("st_udf", 32'(udf_cnt), 1);
        buf_out_clear = 1'b1;
        step();
        buf_out_clear = 1'b0;
        check("st_clr", {16'd0, ovf_cnt, udf_cnt}, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
